// File: rtl/tlp_link_transmitter.sv
// tlp_link_transmitter: round-robin drain of three flagged TLP buffers onto one 32-bit link.
// Optional data_parity output enabled by TLP_TX_PARITY_EN.
module tlp_link_transmitter #(
  parameter int LINK_NUMBER = 0,
  parameter int MAX_WORDS   = 1028
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [34:0] data_in0,
  input  logic [34:0] data_in1,
  input  logic [34:0] data_in2,
  input  logic        valid0,
  input  logic        valid1,
  input  logic        valid2,
  output logic        pop0,
  output logic        pop1,
  output logic        pop2,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic        data_last,
  input  logic        link_ready,
  output logic        drop_pulse,
  output logic        overrun_pulse
`ifdef TLP_TX_PARITY_EN
  ,
  output logic        data_parity
`endif
);
  localparam int CW = $clog2(MAX_WORDS + 1);
  typedef enum logic [1:0] {IDLE, XFER, DROP} state_t;
  state_t state_q, state_d;
  logic [1:0] ptr_q, ptr_d, gnt_q, gnt_d, p1, p2, sel;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] data_out_q, data_out_d;
  logic data_valid_q, data_valid_d, data_last_q, data_last_d;
  logic drop_q, drop_d, ovr_q, ovr_d;
  logic [2:0] vld;
  logic [34:0] din_g, din_s;
  logic vld_g, slot_free, xfer, cap, last_w;
`ifdef TLP_TX_PARITY_EN
  logic par_q, par_d;
  assign data_parity = par_q;
`endif
  function automatic logic [1:0] inc3(input logic [1:0] x);
    return x == 2'd2 ? 2'd0 : x + 2'd1;
  endfunction
  assign vld = {valid2, valid1, valid0};
  assign p1 = inc3(ptr_q);
  assign p2 = inc3(p1);
  assign sel = vld[ptr_q] ? ptr_q : vld[p1] ? p1 : p2;
  assign din_s = sel == 2'd2 ? data_in2 : sel == 2'd1 ? data_in1 : data_in0;
  assign din_g = gnt_q == 2'd2 ? data_in2 : gnt_q == 2'd1 ? data_in1 : data_in0;
  assign vld_g = vld[gnt_q];
  assign slot_free = !data_valid_q | link_ready;
  // DROP drains regardless of the output slot; XFER must wait for room
  assign xfer = !reset & vld_g & (state_q == DROP | (state_q == XFER & slot_free));
  assign cap = cnt_q + CW'(1) == CW'(MAX_WORDS);
  assign last_w = !din_g[34] | cap;
  assign {pop2, pop1, pop0} = xfer ? 3'b001 << gnt_q : 3'b000;
  assign data_out = data_out_q;
  assign data_valid = data_valid_q;
  assign data_last = data_last_q;
  assign drop_pulse = drop_q;
  assign overrun_pulse = ovr_q;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    gnt_d = gnt_q;
    cnt_d = cnt_q;
    data_out_d = data_out_q;
    data_valid_d = data_valid_q & !link_ready;
    data_last_d = data_last_q;
    drop_d = 1'b0;
    ovr_d = 1'b0;
`ifdef TLP_TX_PARITY_EN
    par_d = par_q;
`endif
    if (state_q == IDLE && |vld) begin
      gnt_d = sel;
      cnt_d = '0;
      state_d = din_s[33:32] == 2'(LINK_NUMBER) ? XFER : DROP;
    end
    if (xfer) begin
      cnt_d = cnt_q + CW'(1);
      ptr_d = last_w ? inc3(gnt_q) : ptr_q;
      state_d = last_w ? IDLE : state_q;
      drop_d = state_q == DROP & last_w;
    end
    if (xfer && state_q == XFER) begin
      data_out_d = din_g[31:0];
      data_valid_d = 1'b1;
      data_last_d = last_w;
      ovr_d = cap & din_g[34];
`ifdef TLP_TX_PARITY_EN
      par_d = ^din_g[31:0];
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      gnt_q <= '0;
      cnt_q <= '0;
      data_out_q <= '0;
      data_valid_q <= 1'b0;
      data_last_q <= 1'b0;
      drop_q <= 1'b0;
      ovr_q <= 1'b0;
`ifdef TLP_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
      cnt_q <= cnt_d;
      data_out_q <= data_out_d;
      data_valid_q <= data_valid_d;
      data_last_q <= data_last_d;
      drop_q <= drop_d;
      ovr_q <= ovr_d;
`ifdef TLP_TX_PARITY_EN
      par_q <= par_d;
`endif
    end
  end
endmodule
